weight_fifo: RTL and testbench

WEIGHT_FIFO -- requirements
Module: weight_fifo

---
 rtl/weight_fifo.sv | 149 ++++++++++++++
 tb/tb_weight_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fifo.sv
// Per-lane weight FIFO feeding a systolic array: rows are pushed across all lanes at once and
// drained per lane, optionally staggered so lane i starts i cycles after lane 0.
module weight_fifo_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W      = 4,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr,
  input  logic [PTR_W-1:0]      i_wptr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_pop_req,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic [CNT_W-1:0]      o_cnt
);
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  w_pop;

  assign w_pop = i_pop_req && (r_cnt != '0);

  // Storage is never reset; occupancy alone decides what is live.
  always_ff @(posedge clk)
    if (i_wr) r_mem[i_wptr] <= i_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_pop)
        r_rptr <= (r_rptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_rptr + PTR_W'(1);
      if (i_wr && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (!i_wr && w_pop) r_cnt <= r_cnt - CNT_W'(1);
      // Zero-fill non-popping cycles so the array sees clean bubbles.
      r_rd_valid <= w_pop;
      r_rd_data  <= w_pop ? r_mem[r_rptr] : '0;
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_cnt      = r_cnt;
endmodule

module weight_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_INPUTS = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_en,
  input  logic [FIFO_INPUTS*DATA_WIDTH-1:0] wr_data,
  input  logic [FIFO_INPUTS-1:0]            fifo_en,
  input  logic                              stagger,
  output logic [FIFO_INPUTS*DATA_WIDTH-1:0] rd_data,
  output logic [FIFO_INPUTS-1:0]            rd_valid,
  output logic                              full,
  output logic                              empty,
  output logic [CNT_W-1:0]                  count
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DC_W  = $clog2(FIFO_INPUTS + 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]                        r_state;
  logic [DC_W-1:0]                   r_dc;
  logic                              r_stg;
  logic [PTR_W-1:0]                  r_wptr;
  logic                              w_wr;
  logic                              w_stg;
  logic [DC_W-1:0]                   w_e;
  logic [FIFO_INPUTS-1:0]            w_go;
  logic [FIFO_INPUTS-1:0]            w_lfull;
  logic [FIFO_INPUTS-1:0]            w_lempty;
  logic [FIFO_INPUTS-1:0][CNT_W-1:0] w_cnt;

  assign w_wr  = wr_en && !full;
  // Stagger is only honoured at drain start; inside DRAIN the latched copy rules.
  assign w_stg = (r_state == S_IDLE) ? stagger : r_stg;
  assign w_e   = (r_state == S_IDLE) ? '0 : r_dc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dc    <= '0;
      r_stg   <= 1'b0;
      r_wptr  <= '0;
    end else begin
      if (w_wr)
        r_wptr <= (r_wptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_wptr + PTR_W'(1);
      case (r_state)
        S_IDLE:
          if (fifo_en[0]) begin
            r_state <= S_DRAIN;
            r_stg   <= stagger;
            r_dc    <= DC_W'(1);
          end
        default:
          if (!fifo_en[0]) begin
            r_state <= S_IDLE;
            r_dc    <= '0;
          end else if (r_dc != DC_W'(FIFO_INPUTS)) begin
            r_dc <= r_dc + DC_W'(1);
          end
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < FIFO_INPUTS; g++) begin : g_lane
      assign w_go[g]     = !w_stg || (w_e >= DC_W'(g));
      assign w_lfull[g]  = (w_cnt[g] == CNT_W'(FIFO_DEPTH));
      assign w_lempty[g] = (w_cnt[g] == '0);
      weight_fifo_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_W      (PTR_W),
        .CNT_W      (CNT_W)
      ) u_lane (
        .clk        (clk),
        .reset      (reset),
        .i_wr       (w_wr),
        .i_wptr     (r_wptr),
        .i_wdata    (wr_data[g*DATA_WIDTH +: DATA_WIDTH]),
        .i_pop_req  (fifo_en[g] && w_go[g]),
        .o_rd_data  (rd_data[g*DATA_WIDTH +: DATA_WIDTH]),
        .o_rd_valid (rd_valid[g]),
        .o_cnt      (w_cnt[g])
      );
    end
  endgenerate

  assign full  = |w_lfull;
  assign empty = &w_lempty;
  assign count = w_cnt[FIFO_INPUTS-1];
endmodule

// File: tb/tb_weight_fifo.sv
// Scoreboard bench for weight_fifo: each driven cycle queues the expected registered output row.
module tb_weight_fifo;
  localparam int DW = 8;
  localparam int NI = 16;
  localparam int CW = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [NI*DW-1:0] wr_data;
  logic [NI-1:0]    fifo_en;
  logic             stagger;
  logic [NI*DW-1:0] rd_data;
  logic [NI-1:0]    rd_valid;
  logic             full, empty;
  logic [CW-1:0]    count;

  typedef struct packed {
    logic [NI-1:0]    v;
    logic [NI*DW-1:0] d;
  } exp_t;
  exp_t q[$];
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  weight_fifo #(.DATA_WIDTH(DW), .FIFO_INPUTS(NI), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .fifo_en(fifo_en),
    .stagger(stagger), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .count(count)
  );

  function automatic logic [NI*DW-1:0] mkrow(input int k);
    logic [NI*DW-1:0] r;
    for (int i = 0; i < NI; i++) r[i*DW +: DW] = 8'(16*k + i);
    return r;
  endfunction

  // Expected output of a staggered drain for enable cycle t over rows base..base+15.
  function automatic exp_t stg_exp(input int base, input int t);
    exp_t e;
    logic [NI*DW-1:0] r;
    e = '0;
    for (int i = 0; i < NI; i++) begin
      if (t >= i && t - i < 16) begin
        r = mkrow(base + t - i);
        e.v[i] = 1'b1;
        e.d[i*DW +: DW] = r[i*DW +: DW];
      end
    end
    return e;
  endfunction

  task automatic drv(input logic we, input logic [NI*DW-1:0] wd, input logic [NI-1:0] fe,
                     input logic st);
    wr_en = we; wr_data = wd; fifo_en = fe; stagger = st;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drv(1'b0, '0, '0, 1'b0);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    checks++; if (full !== 1'b0) begin errs++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (count !== 5'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (rd_valid !== '0 || rd_data !== '0) begin
      errs++; $display("FAIL reset_out: got v=%h d=%h want 0", rd_valid, rd_data); end
  endtask

  task automatic test_flat(input int base);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      drv(1'b1, mkrow(base + k), '0, 1'b0);
      q.push_back('0);
      step();
      e = q.pop_front(); checks++;
      if (rd_valid !== e.v || rd_data !== e.d) begin
        errs++; $display("FAIL flat_fill[%0d]: got v=%h d=%h want v=%h d=%h", k, rd_valid, rd_data, e.v, e.d); end
    end
    checks++; if (full !== 1'b1 || count !== 5'd16) begin
      errs++; $display("FAIL flat_full: got full=%b count=%0d want 1/16", full, count); end
    for (int k = 0; k < 16; k++) begin
      drv(1'b0, '0, '1, 1'b0);
      q.push_back({{NI{1'b1}}, mkrow(base + k)});
      step();
      e = q.pop_front(); checks++;
      if (rd_valid !== e.v || rd_data !== e.d) begin
        errs++; $display("FAIL flat_drain[%0d]: got v=%h d=%h want v=%h d=%h", k, rd_valid, rd_data, e.v, e.d); end
    end
    drv(1'b0, '0, '0, 1'b0);
    q.push_back('0);
    step();
    e = q.pop_front(); checks++;
    if (rd_valid !== e.v || rd_data !== e.d) begin
      errs++; $display("FAIL flat_tail: got v=%h d=%h want 0", rd_valid, rd_data); end
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin
      errs++; $display("FAIL flat_empty: got empty=%b count=%0d want 1/0", empty, count); end
  endtask

  task automatic test_stagger();
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      drv(1'b1, mkrow(20 + k), '0, 1'b0);
      step();
    end
    // stagger drops mid-drain; the latched mode must persist
    for (int t = 0; t < 32; t++) begin
      drv(1'b0, '0, '1, (t < 3) ? 1'b1 : 1'b0);
      q.push_back(stg_exp(20, t));
      step();
      e = q.pop_front(); checks++;
      if (rd_valid !== e.v || rd_data !== e.d) begin
        errs++; $display("FAIL stagger_out[%0d]: got v=%h d=%h want v=%h d=%h", t + 1, rd_valid, rd_data, e.v, e.d); end
    end
    drv(1'b0, '0, '0, 1'b0);
    step();
    checks++; if (empty !== 1'b1 || rd_valid !== '0) begin
      errs++; $display("FAIL stagger_empty: got empty=%b v=%h want 1/0", empty, rd_valid); end
  endtask

  task automatic test_full();
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      drv(1'b1, mkrow(40 + k), '0, 1'b0);
      step();
    end
    checks++; if (full !== 1'b1 || count !== 5'd16) begin
      errs++; $display("FAIL full_set: got full=%b count=%0d want 1/16", full, count); end
    drv(1'b1, mkrow(56), '0, 1'b0);
    step();
    checks++; if (full !== 1'b1 || count !== 5'd16) begin
      errs++; $display("FAIL full_drop: got full=%b count=%0d want 1/16", full, count); end
    drv(1'b1, mkrow(57), '1, 1'b0);
    q.push_back({{NI{1'b1}}, mkrow(40)});
    step();
    e = q.pop_front(); checks++;
    if (rd_valid !== e.v || rd_data !== e.d) begin
      errs++; $display("FAIL full_pop: got v=%h d=%h want v=%h d=%h", rd_valid, rd_data, e.v, e.d); end
    checks++; if (full !== 1'b0 || count !== 5'd15) begin
      errs++; $display("FAIL full_poppush: got full=%b count=%0d want 0/15", full, count); end
    drv(1'b1, mkrow(58), '0, 1'b0);
    step();
    checks++; if (full !== 1'b1 || count !== 5'd16) begin
      errs++; $display("FAIL full_refill: got full=%b count=%0d want 1/16", full, count); end
    for (int k = 0; k < 16; k++) begin
      drv(1'b0, '0, '1, 1'b0);
      q.push_back({{NI{1'b1}}, mkrow((k < 15) ? 41 + k : 58)});
      step();
      e = q.pop_front(); checks++;
      if (rd_valid !== e.v || rd_data !== e.d) begin
        errs++; $display("FAIL full_drain[%0d]: got v=%h d=%h want v=%h d=%h", k, rd_valid, rd_data, e.v, e.d); end
    end
    drv(1'b0, '0, '0, 1'b0);
    step();
    checks++; if (empty !== 1'b1) begin errs++; $display("FAIL full_empty: got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, mkrow(60 + k), '0, 1'b0);
      step();
    end
    for (int j = 0; j < 40; j++) begin
      drv(1'b1, mkrow(64 + j), '1, 1'b0);
      q.push_back({{NI{1'b1}}, mkrow(60 + j)});
      step();
      e = q.pop_front(); checks++;
      if (rd_valid !== e.v || rd_data !== e.d || count !== 5'd4) begin
        errs++; $display("FAIL b2b[%0d]: got v=%h d=%h cnt=%0d want v=%h d=%h cnt=4", j, rd_valid, rd_data, count, e.v, e.d); end
    end
    for (int j = 0; j < 4; j++) begin
      drv(1'b0, '0, '1, 1'b0);
      q.push_back({{NI{1'b1}}, mkrow(100 + j)});
      step();
      e = q.pop_front(); checks++;
      if (rd_valid !== e.v || rd_data !== e.d) begin
        errs++; $display("FAIL b2b_tail[%0d]: got v=%h d=%h want v=%h d=%h", j, rd_valid, rd_data, e.v, e.d); end
    end
    drv(1'b0, '0, '0, 1'b0);
    step();
    checks++; if (empty !== 1'b1) begin errs++; $display("FAIL b2b_empty: got %b want 1", empty); end
  endtask

  task automatic test_empty_pop();
    exp_t e;
    for (int t = 0; t < 3; t++) begin
      drv(1'b0, '0, '1, 1'b1);
      q.push_back('0);
      step();
      e = q.pop_front(); checks++;
      if (rd_valid !== e.v || rd_data !== e.d || empty !== 1'b1 || count !== 5'd0) begin
        errs++; $display("FAIL empty_pop[%0d]: got v=%h d=%h empty=%b cnt=%0d want 0/0/1/0", t, rd_valid, rd_data, empty, count); end
    end
    drv(1'b1, mkrow(70), '0, 1'b0);
    step();
    drv(1'b0, '0, '1, 1'b0);
    q.push_back({{NI{1'b1}}, mkrow(70)});
    step();
    e = q.pop_front(); checks++;
    if (rd_valid !== e.v || rd_data !== e.d) begin
      errs++; $display("FAIL empty_pop_after: got v=%h d=%h want v=%h d=%h", rd_valid, rd_data, e.v, e.d); end
    drv(1'b0, '0, '0, 1'b0);
    step();
  endtask

  task automatic test_reset_mid_drain();
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      drv(1'b1, mkrow(80 + k), '0, 1'b0);
      step();
    end
    for (int t = 0; t < 5; t++) begin
      drv(1'b0, '0, '1, 1'b1);
      q.push_back(stg_exp(80, t));
      step();
      e = q.pop_front(); checks++;
      if (rd_valid !== e.v || rd_data !== e.d) begin
        errs++; $display("FAIL rst_drain[%0d]: got v=%h d=%h want v=%h d=%h", t + 1, rd_valid, rd_data, e.v, e.d); end
    end
    drv(1'b1, mkrow(99), '1, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (rd_valid !== '0 || rd_data !== '0 || empty !== 1'b1 || count !== 5'd0 || full !== 1'b0) begin
      errs++; $display("FAIL rst_mid: got v=%h d=%h empty=%b cnt=%0d full=%b want 0/0/1/0/0", rd_valid, rd_data, empty, count, full); end
    drv(1'b0, '0, '0, 1'b0);
    step();
    test_flat(110);
  endtask

  initial begin
    reset = 1'b1;
    drv(1'b0, '0, '0, 1'b0);
    test_reset();
    test_flat(0);
    test_stagger();
    test_full();
    test_back_to_back();
    test_empty_pop();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
